// File: rtl/uart_tx_frame.sv
// uart_tx_frame: valid/ready parallel-to-serial UART transmitter.
// Frame = start(0), DATA_BITS data bits LSB first, optional even parity, stop(1).
// Each bit is held for CLKS_PER_BIT clocks. The line idles high.
// Optional feature macro: UART_TX_PARITY_EN (adds one even-parity bit per frame).
module uart_tx_frame #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
`ifdef UART_TX_PARITY_EN
  logic                   parity_bit;
`endif

  // Handshake/status decoded from the registered state only.
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

  // Frame sequencer: each state holds its line level for one full bit period.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '1;
      serial_out <= 1'b1;
      frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt   <= '0;
          bit_cnt    <= '0;
          serial_out <= 1'b1;
          if (tx_valid) begin
            shift_reg  <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
            serial_out <= 1'b0;
            state      <= START;
          end
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt   <= '0;
            serial_out <= shift_reg[0];
            state      <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b1, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              serial_out <= parity_bit;
              state      <= PARITY;
`else
              serial_out <= 1'b1;
              state      <= STOP;
`endif
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              serial_out <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt   <= '0;
            serial_out <= 1'b1;
            state      <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          // Registered pulse lands in the final cycle of the stop bit.
          if (baud_cnt == BAUD_PRE) begin
            frame_done <= 1'b1;
          end
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt   <= '0;
            serial_out <= 1'b1;
            state      <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          baud_cnt   <= '0;
          bit_cnt    <= '0;
          serial_out <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame. Stimulus pushes the
// expected word; a line monitor watches serial_out, decodes each frame and
// compares it against a bit-sequence model built from the frame format.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_frame;

  localparam int unsigned DB = 8;
  localparam int unsigned B  = 10;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = DB + 3;
`else
  localparam int unsigned NBITS = DB + 2;
`endif
  localparam int unsigned L = NBITS * B;

  logic          clk;
  logic          n_rst;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          serial_out;
  logic          tx_busy;
  logic          frame_done;

  uart_tx_frame #(.DATA_BITS(DB), .CLKS_PER_BIT(B)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    bit            b2b;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   pushed  = 0;
  int   frames  = 0;
  int   aborts  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: line level of frame bit slot idx for word d.
  function automatic logic exp_bit(input logic [DB-1:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= int'(DB)) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == int'(DB) + 1) return logic'($countones(d) % 2);
`endif
    return 1'b1;
  endfunction

  // Line monitor / scoreboard.
  exp_t          cur;
  logic [DB-1:0] rx;
  int            bad_cyc, done_cnt, done_pos, start_cyc, prev_last, idx;
  bit            aborted;
  initial begin
    prev_last = -100;
    forever begin
      @(negedge clk);
      if (n_rst !== 1'b1) continue;
      if (serial_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'(exp_q.size()), 32'd1);
          continue;
        end
        cur = exp_q.pop_front();
        start_cyc = cyc;
        rx = '0; bad_cyc = 0; done_cnt = 0; done_pos = 0; aborted = 0;
        for (int c = 1; c <= int'(L); c++) begin
          if (c > 1) @(negedge clk);
          if (n_rst !== 1'b1) begin
            aborted = 1;
            break;
          end
          idx = (c - 1) / int'(B);
          if (serial_out !== exp_bit(cur.data, idx)) bad_cyc++;
          if (tx_busy !== 1'b1 || tx_ready !== 1'b0) bad_cyc++;
          if (frame_done === 1'b1) begin
            done_cnt++;
            done_pos = c;
          end
          if (idx >= 1 && idx <= int'(DB) && ((c - 1) % int'(B)) == int'(B) / 2)
            rx[idx-1] = serial_out;
        end
        if (aborted) begin
          aborts++;
          chk("abort_no_done", 32'(done_cnt), 32'd0);
          continue;
        end
        frames++;
        chk("rx_data", 32'(rx), 32'(cur.data));
        chk("line_timing_bad_cycles", 32'(bad_cyc), 32'd0);
        chk("frame_done_count", 32'(done_cnt), 32'd1);
        chk("frame_done_pos", 32'(done_pos), 32'(L));
        if (cur.b2b) chk("b2b_gap", 32'(start_cyc - prev_last), 32'd2);
        prev_last = cyc;
        @(negedge clk);
        if (n_rst === 1'b1)
          chk("ready_after_frame", {29'd0, tx_ready, serial_out, frame_done}, 32'b110);
      end else begin
        chk("idle_state", {29'd0, tx_ready, tx_busy, frame_done}, 32'b100);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (tx_ready !== 1'b1) chk("ready_timeout", {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic send(input logic [DB-1:0] d, input bit b2b);
    wait_ready();
    exp_q.push_back('{data: d, b2b: b2b});
    pushed++;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  logic [DB-1:0] dirs[4];

  initial begin
    n_rst    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {28'd0, serial_out, tx_ready, tx_busy, frame_done}, 32'b1100);
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_outputs", {28'd0, serial_out, tx_ready, tx_busy, frame_done}, 32'b1100);

    // Directed words: pattern, parity-one, all-zero, all-one.
    dirs[0] = 8'hA5; dirs[1] = 8'h01; dirs[2] = 8'h00; dirs[3] = 8'hFF;
    foreach (dirs[i]) send(dirs[i], 1'b0);

    // Back-to-back with tx_valid held high throughout.
    wait_ready();
    exp_q.push_back('{data: 8'h00, b2b: 1'b0}); pushed++;
    tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{data: 8'hFF, b2b: 1'b1}); pushed++;
    tx_data = 8'hFF;
    wait_ready();
    @(posedge clk); #1;
    tx_valid = 1'b0;

    // Input changes while busy must not disturb the latched word.
    send(8'h3C, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    tx_data = 8'hC3; tx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_valid = 1'b0;

    // Mid-frame reset during data bit 3 (bit 3 of 0x96 is 0).
    send(8'h96, 1'b0);
    pushed--;
    repeat (44) @(posedge clk);
    #1;
    chk("pre_abort_line_low", {31'd0, serial_out}, 32'd0);
    n_rst = 1'b0;
    #1;
    chk("abort_outputs", {28'd0, serial_out, tx_ready, tx_busy, frame_done}, 32'b1100);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    send(8'h55, 1'b0);

    // Randomized words with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      wait_ready();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      send(DB'($urandom), 1'b0);
    end

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
        @(posedge clk); n++;
      end
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
    end
    wait_ready();
    repeat (3) @(posedge clk);
    chk("aborted_frames", 32'(aborts), 32'd1);
    chk("completed_frames", 32'(frames), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parallel-to-serial UART transmitter: accepts one data word over a valid/ready handshake and drives it onto a single serial line as start bit, data LSB first, optional parity and stop bit. Each bit is held for a fixed number of clock cycles. It is the transmit-side counterpart of the lab's serial-to-parallel receive path, which shifts toward the LSB. Its line idles high, matching the all-ones reset of that path. Sits between a byte source (FIFO/controller) and the chip's serial output pin.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 10, clock cycles each serial bit is held; legal >= 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  word to send; sampled only at acceptance.
- tx_valid  input  1  source has a word on tx_data.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- serial_out  output  1  registered serial line; idle/stop = 1, start = 0.
- tx_busy  output  1  high whenever state != IDLE.
- frame_done  output  1  single-cycle pulse during the last cycle of the stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY (present only with UART_TX_PARITY_EN), STOP.
- Acceptance:
  - Occurs on a rising edge where tx_valid && tx_ready.
  - tx_data is copied into an internal shift register, bit counter = 0, baud counter = 0, state -> START.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - At CLKS_PER_BIT-1 it wraps to 0 and the state/bit advances.
- START: serial_out = 0 for CLKS_PER_BIT cycles -> DATA.
- DATA:
  - serial_out = shift_reg[0].
  - On each bit boundary, shift right by one and increment the bit counter.
  - After DATA_BITS bits -> PARITY if enabled, else STOP.
- PARITY: serial_out = even parity (XOR of all latched data bits) for CLKS_PER_BIT cycles -> STOP.
- STOP:
  - serial_out = 1 for CLKS_PER_BIT cycles.
  - frame_done = 1 in the final one.
  - -> IDLE.
- IDLE: serial_out = 1, tx_ready = 1, tx_busy = 0; counters held at 0.
- tx_valid or tx_data changes while busy are ignored; the latched word is transmitted unchanged.
- tx_valid held high continuously produces back-to-back frames separated by exactly one idle-high cycle.
- Reset values: serial_out = 1, tx_ready = 1, tx_busy = 0, frame_done = 0, state IDLE, counters 0, shift register all ones.
- Reset mid-frame aborts immediately and asynchronously: serial_out goes to 1 with no partial stop bit. No frame_done is issued.

## Timing
- Call the acceptance edge E0.
- Start bit on serial_out from after E0 through E_CLKS_PER_BIT.
- Data bit k (0-based) occupies edges E((k+1)·CLKS_PER_BIT) .. E((k+2)·CLKS_PER_BIT).
- Frame length in cycles, with B = CLKS_PER_BIT:
  - Without parity: (DATA_BITS+2)·B.
  - With parity: (DATA_BITS+3)·B.
- frame_done is high in the last cycle before the return to IDLE.
- tx_ready rises in the cycle after frame_done falls.
- tx_ready is decoded combinationally from the registered state and therefore has no combinational path from tx_valid.
- serial_out is a flop output, glitch-free.

## Configuration
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is compiled in.
  - One even-parity bit is inserted between the last data bit and the stop bit.
  - Frame grows by CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state or parity logic.
  - DATA goes directly to STOP.

## Test plan
- Reset: n_rst low for 2 cycles -> serial_out = 1, tx_ready = 1, tx_busy = 0, frame_done = 0. Release -> values unchanged.
- Single frame, defaults, no parity, tx_data = 0xA5 accepted at E0:
  - serial_out = 0 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles.
  - frame_done pulses once in cycle 100.
  - tx_ready returns at E100.
- Parity build, tx_data = 0xA5 -> parity bit 0 in cycles 91–100, stop 101–110. tx_data = 0x01 -> parity bit 1.
- Back-to-back:
  - tx_valid held high with 0x00 then 0xFF.
  - Exactly one idle-high cycle between the first stop bit and the second start bit.
  - 0xFF yields 80 consecutive high data cycles.
- Data stability: change tx_data from 0x3C to 0xC3 at E5 of a 0x3C frame -> line still carries 0x3C.
- Mid-frame reset: assert n_rst during data bit 3 -> serial_out = 1 immediately, no frame_done. A new frame 0x55 after release transmits correctly from the start bit.
